// File: rtl/pb_debounce_if.sv
// Button-side bundle for pb_debounce: raw active-low pins in, debounced level
// and single-cycle press/release/long events out.
interface pb_debounce_if #(
  parameter int N = 4
);
  logic [N-1:0] pb;
  logic [N-1:0] pb_level;
  logic [N-1:0] pb_press;
  logic [N-1:0] pb_release;
  logic [N-1:0] pb_long;

  modport master (
    output pb,
    input  pb_level, pb_press, pb_release, pb_long
  );

  modport slave (
    input  pb,
    output pb_level, pb_press, pb_release, pb_long
  );
endinterface

// File: rtl/pb_debounce.sv
// N-channel pushbutton debouncer: 2-FF sync, 4-state debounce FSM and, when
// PB_LONGPRESS_EN is defined, a per-channel hold timer raising pb_long.
module pb_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int LONG_CYCLES     = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_n,
  output logic level,
  output logic press,
  output logic rel,
  output logic lng
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_RELEASE_WAIT
  } state_e;

  logic [1:0]    sync_q, sync_d;
  state_e        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          s;

  // Sync flops idle at 1 so a released pin looks quiet straight out of reset.
  assign sync_d = {sync_q[0], pb_n};
  assign s      = ~sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      ST_RELEASED: begin
        if (s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = DW'(1);
        end
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = DW'(1);
        end
      end
      ST_RELEASE_WAIT: begin
        if (s) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_RELEASED;
          level_d = 1'b0;
          rel_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rel   = rel_q;

`ifdef PB_LONGPRESS_EN
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 2);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  // Timer keeps running through RELEASE_WAIT so a bounce mid-hold does not
  // restart it; it saturates at HOLD_LAST so pb_long fires once per press.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (press_d) begin
      hold_d = '0;
    end else if ((state_q == ST_PRESSED || state_q == ST_RELEASE_WAIT) &&
                 hold_q != HOLD_LAST) begin
      hold_d = hold_q + 1'b1;
      long_d = (hold_q == HOLD_FIRE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign lng = long_q;
`else
  assign lng = 1'b0;
`endif
endmodule

module pb_debounce #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int LONG_CYCLES     = 10000000
) (
  input  logic         clk,
  input  logic         rst,
  pb_debounce_if.slave bus
);
  logic [N-1:0] level_w;
  logic [N-1:0] press_w;
  logic [N-1:0] rel_w;
  logic [N-1:0] long_w;

  for (genvar i = 0; i < N; i++) begin : g_lane
    pb_debounce_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst),
      .pb_n (bus.pb[i]),
      .level(level_w[i]),
      .press(press_w[i]),
      .rel  (rel_w[i]),
      .lng  (long_w[i])
    );
  end

  assign bus.pb_level   = level_w;
  assign bus.pb_press   = press_w;
  assign bus.pb_release = rel_w;
  assign bus.pb_long    = long_w;
endmodule

// File: tb/tb_pb_debounce.sv
// Directed bench for pb_debounce (N=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=20);
// long-press expectations follow whether PB_LONGPRESS_EN is defined.
module tb_pb_debounce;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

`ifdef PB_LONGPRESS_EN
  localparam logic [3:0] LONG_EXP = 4'b0001;
`else
  localparam logic [3:0] LONG_EXP = 4'b0000;
`endif

  pb_debounce_if #(.N(4)) bus ();

  pb_debounce #(
    .N(4), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all0(input string tag);
    chk({tag, "_level"},   bus.pb_level,   4'b0000);
    chk({tag, "_press"},   bus.pb_press,   4'b0000);
    chk({tag, "_release"}, bus.pb_release, 4'b0000);
    chk({tag, "_long"},    bus.pb_long,    4'b0000);
  endtask

  initial begin
    logic [3:0] acc_long;
    logic [3:0] acc_rel;
    logic [11:0] bounce;

    // Reset with all buttons held down
    bus.pb = 4'b0000;
    rst    = 1'b0;
    cyc(3);
    chk_all0("reset");
    rst = 1'b1;
    cyc(5);
    chk("rst_press_e5", bus.pb_press, 4'b0000);
    cyc(1);
    chk("rst_press_e6", bus.pb_press, 4'b1111);
    chk("rst_level_e6", bus.pb_level, 4'b1111);
    cyc(1);
    chk("rst_press_e7", bus.pb_press, 4'b0000);
    chk("rst_level_e7", bus.pb_level, 4'b1111);
    bus.pb = 4'b1111;
    cyc(6);
    chk("rst_rel_e6", bus.pb_release, 4'b1111);
    chk("rst_rel_lvl", bus.pb_level, 4'b0000);
    cyc(1);
    chk("rst_rel_e7", bus.pb_release, 4'b0000);
    cyc(3);

    // Clean press/release on pb[1]
    bus.pb = 4'b1101;
    cyc(5);
    chk("p1_press_e5", bus.pb_press, 4'b0000);
    cyc(1);
    chk("p1_press_e6", bus.pb_press, 4'b0010);
    chk("p1_level_e6", bus.pb_level, 4'b0010);
    cyc(1);
    chk("p1_press_e7", bus.pb_press, 4'b0000);
    bus.pb = 4'b1111;
    cyc(5);
    chk("p1_rel_e5", bus.pb_release, 4'b0000);
    chk("p1_lvl_e5", bus.pb_level, 4'b0010);
    cyc(1);
    chk("p1_rel_e6", bus.pb_release, 4'b0010);
    chk("p1_lvl_e6", bus.pb_level, 4'b0000);
    cyc(1);
    chk("p1_rel_e7", bus.pb_release, 4'b0000);
    cyc(3);

    // Bounce on pb[2]: low 3, high 1, low 3, then high
    bounce = 12'b111110001000;
    for (int i = 0; i < 12; i++) begin
      bus.pb = {1'b1, bounce[i], 2'b11};
      cyc(1);
      chk("bnc_press", bus.pb_press, 4'b0000);
      chk("bnc_rel",   bus.pb_release, 4'b0000);
      chk("bnc_level", bus.pb_level, 4'b0000);
    end
    bus.pb = 4'b1011;
    cyc(5);
    chk("bnc_steady_e5", bus.pb_press, 4'b0000);
    cyc(1);
    chk("bnc_steady_e6", bus.pb_press, 4'b0100);
    chk("bnc_steady_lvl", bus.pb_level, 4'b0100);
    bus.pb = 4'b1111;
    cyc(6);
    chk("bnc_rel_e6", bus.pb_release, 4'b0100);
    cyc(4);

    // Long press on pb[0]
    bus.pb = 4'b1110;
    cyc(6);
    chk("lp_press", bus.pb_press, 4'b0001);
    cyc(18);
    chk("lp_long_m1", bus.pb_long, 4'b0000);
    cyc(1);
    chk("lp_long", bus.pb_long, LONG_EXP);
    cyc(1);
    chk("lp_long_p1", bus.pb_long, 4'b0000);
    acc_long = '0;
    acc_rel  = '0;
    for (int i = 0; i < 75; i++) begin
      cyc(1);
      acc_long |= bus.pb_long;
      acc_rel  |= bus.pb_release;
    end
    chk("lp_hold_long", acc_long, 4'b0000);
    chk("lp_hold_rel", acc_rel, 4'b0000);
    // 2-cycle high glitch mid-hold
    bus.pb = 4'b1111;
    cyc(2);
    bus.pb = 4'b1110;
    acc_long = '0;
    acc_rel  = '0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      acc_long |= bus.pb_long;
      acc_rel  |= bus.pb_release;
    end
    chk("lp_glitch_long", acc_long, 4'b0000);
    chk("lp_glitch_rel", acc_rel, 4'b0000);
    chk("lp_glitch_lvl", bus.pb_level, 4'b0001);
    bus.pb = 4'b1111;
    cyc(6);
    chk("lp_rel", bus.pb_release, 4'b0001);
    chk("lp_rel_lvl", bus.pb_level, 4'b0000);
    cyc(4);

    // Simultaneous press on pb[3] and pb[0], then reset during RELEASE_WAIT
    bus.pb = 4'b0110;
    cyc(6);
    chk("sim_press", bus.pb_press, 4'b1001);
    chk("sim_level", bus.pb_level, 4'b1001);
    bus.pb = 4'b1111;
    cyc(4);
    chk("sim_rw_lvl", bus.pb_level, 4'b1001);
    chk("sim_rw_rel", bus.pb_release, 4'b0000);
    rst = 1'b0;
    #1;
    chk_all0("midrst");
    acc_rel = '0;
    cyc(3);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      acc_rel |= bus.pb_release | bus.pb_press | bus.pb_level;
    end
    chk("postrst_quiet", acc_rel, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pb_debounce.md
# pb_debounce

Debounced pushbutton reader for the gm-proto-e1 board: N active-low button pins in, clean per-button level plus single-cycle press, release and long-press events out. It is the input-side counterpart to the LED-driving demo blocks: same 10 MHz system clock, same board-level reset. Each channel gets a 2-FF synchronizer, a debounce state machine, and an optional hold timer.

## Interface
- N, 4: number of button channels (1..8)
- DEBOUNCE_CYCLES, 100000: consecutive stable cycles required to accept a change (10 ms at 10 MHz); must be ≥ 2
- LONG_CYCLES, 10000000: cycles a press must be held to raise a long-press event (1 s at 10 MHz); must be ≥ 2
- clk  input  1  system clock (10 MHz)
- rst  input  1  asynchronous, active-low reset
- pb  input  N  raw button pins, active-low (0 = pressed), asynchronous to clk
- pb_level  output  N  debounced state, active-high (1 = pressed)
- pb_press  output  N  one-cycle pulse on accepted press
- pb_release  output  N  one-cycle pulse on accepted release
- pb_long  output  N  one-cycle pulse when a press has been held LONG_CYCLES

## Operation
- Synchronizer: two flops per channel; both reset to 1 (released). The debouncer uses the inverted second flop as `s` (1 = pressed).
- The per-channel FSM has four states:
  - RELEASED: `s`=1 → PRESS_WAIT, with the counter at 1.
  - PRESS_WAIT: `s`=0 → RELEASED, counter cleared. `s`=1 and counter = DEBOUNCE_CYCLES-1 → PRESSED; pb_level←1, pb_press pulses, counter cleared. Otherwise the counter increments.
  - PRESSED: `s`=0 → RELEASE_WAIT, with the counter at 1.
  - RELEASE_WAIT: `s`=1 → PRESSED, counter cleared, no pulse. `s`=0 and counter = DEBOUNCE_CYCLES-1 → RELEASED; pb_level←0, pb_release pulses, counter cleared. Otherwise the counter increments.
- Any glitch shorter than DEBOUNCE_CYCLES produces no event and no pb_level change.
- Hold timer (per channel):
  - Clears on entry to PRESSED via press.
  - Increments each cycle in PRESSED or RELEASE_WAIT.
  - When it reaches LONG_CYCLES-1, pb_long pulses once and the timer saturates.
  - No further pb_long until the next accepted press.
- A bounce during hold (RELEASE_WAIT then back to PRESSED) does not restart the hold timer.
- Width rules: debounce counter is $clog2(DEBOUNCE_CYCLES) bits; hold timer is $clog2(LONG_CYCLES) bits. Neither counter ever wraps.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.

## Timing
- Reset values:
  - pb_level, pb_press, pb_release, pb_long = 0.
  - All FSMs in RELEASED, all counters 0, synchronizers 1.
- Reset asserted mid-operation: everything returns to reset values immediately, and no event pulses are generated.
- Button held through reset deassertion: it is treated as a new press. pb_press follows after normal latency.
- Latency, taking edge 1 as the first clk rising edge sampling the new pin value:
  - Pin stable from edge 1: pb_level/pb_press (or pb_release) are registered at edge DEBOUNCE_CYCLES+2, visible in the following cycle.
  - pb_long follows pb_press by exactly LONG_CYCLES-1 cycles.
- Pulses are exactly one clk cycle wide. pb_press and pb_release are never high together on a channel.
- All outputs are registered; no combinational path from pb.

## Configuration
- PB_LONGPRESS_EN defined: the hold timer and pb_long logic are present as described.
- PB_LONGPRESS_EN undefined: no hold timers are synthesized, pb_long is tied to 0, and the LONG_CYCLES value is ignored. The port list is unchanged.

## Test plan
Bench parameters: N=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, PB_LONGPRESS_EN defined unless stated.

- Reset: hold rst=0 with pb=4'b0000 → all outputs 0. Release rst → pb_press=4'b1111 one cycle at edge 6, then pb_level=4'b1111.
- Clean press/release on pb[1]:
  - Drive 0 at edge 1 → pb_press[1] at edge 6, then pb_level[1]=1.
  - Drive 1 and hold → pb_release[1] 4+2 edges later, then pb_level[1]=0.
- Bounce: pb[2] pulses low for 3 cycles, high 1, low 3 → no events, pb_level[2]=0. A steady low afterwards → pb_press[2] after 6 edges.
- Long press: hold pb[0] low → pb_long[0] exactly 19 cycles after pb_press[0]. A single pulse only, even if held 100 cycles. A 2-cycle high glitch mid-hold gives no pb_release and no second pb_long.
- Simultaneous/reset: press pb[3] and pb[0] on the same edge → both pb_press bits in the same cycle. Assert rst during RELEASE_WAIT → outputs 0, no pb_release.
- Macro off (PB_LONGPRESS_EN undefined): repeat the long-press test → pb_long stays 0; press/release timing identical.
